// File: rtl/if_id_stage_if.sv
// Bundle of the IF/EX-side inputs and ID-side outputs of the IF/ID stage.
// The stage itself connects through the slave modport.
interface if_id_stage_if;
    logic [31:0] instr_i;
    logic [31:0] pc_plus4_i;
    logic        if_valid_i;
    logic        flush_i;
    logic        stall_i;
    logic        ex_mem_read_i;
    logic [4:0]  ex_rt_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_plus4_o;
    logic        id_valid_o;
    logic [5:0]  opcode_o;
    logic [4:0]  rs_o;
    logic [4:0]  rt_o;
    logic [4:0]  rd_o;
    logic [4:0]  shamt_o;
    logic [5:0]  funct_o;
    logic [15:0] imm16_o;
    logic [25:0] jtarget_o;
    logic        lu_stall_o;
    logic        bubble_o;
    logic [15:0] stall_cnt_o;

    modport master (
        output instr_i, pc_plus4_i, if_valid_i, flush_i, stall_i,
               ex_mem_read_i, ex_rt_i,
        input  id_instr_o, id_pc_plus4_o, id_valid_o, opcode_o, rs_o, rt_o,
               rd_o, shamt_o, funct_o, imm16_o, jtarget_o, lu_stall_o,
               bubble_o, stall_cnt_o
    );

    modport slave (
        input  instr_i, pc_plus4_i, if_valid_i, flush_i, stall_i,
               ex_mem_read_i, ex_rt_i,
        output id_instr_o, id_pc_plus4_o, id_valid_o, opcode_o, rs_o, rt_o,
               rd_o, shamt_o, funct_o, imm16_o, jtarget_o, lu_stall_o,
               bubble_o, stall_cnt_o
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with decode field split, load-use hazard detection
// and a saturating count of load-use stall cycles.
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    if_id_stage_if.slave  bus
);
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [31:0] fld_src;
    logic        uses_rt;
    logic        lu_stall;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (bus.flush_i) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
        end else if (!(bus.stall_i || lu_stall)) begin
            instr_d    = bus.if_valid_i ? bus.instr_i : NOP_INSTR;
            pc_plus4_d = bus.pc_plus4_i;
            valid_d    = bus.if_valid_i;
        end
    end

    // Counter sticks at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (lu_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q     <= NOP_INSTR;
            pc_plus4_q  <= 32'h0;
            valid_q     <= 1'b0;
            stall_cnt_q <= 16'h0;
        end else begin
            instr_q     <= instr_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fld_src = valid_q ? instr_q : 32'h0;

    always_comb begin
        case (fld_src[31:26])
            6'h00, 6'h04, 6'h05, 6'h2B: uses_rt = 1'b1;
            default:                    uses_rt = 1'b0;
        endcase
    end

    assign lu_stall = rst_n && valid_q && bus.ex_mem_read_i
                      && (bus.ex_rt_i != 5'd0)
                      && ((bus.ex_rt_i == fld_src[25:21])
                          || (uses_rt && (bus.ex_rt_i == fld_src[20:16])));

    assign bus.id_instr_o    = instr_q;
    assign bus.id_pc_plus4_o = pc_plus4_q;
    assign bus.id_valid_o    = valid_q;
    assign bus.opcode_o      = fld_src[31:26];
    assign bus.rs_o          = fld_src[25:21];
    assign bus.rt_o          = fld_src[20:16];
    assign bus.rd_o          = fld_src[15:11];
    assign bus.shamt_o       = fld_src[10:6];
    assign bus.funct_o       = fld_src[5:0];
    assign bus.imm16_o       = fld_src[15:0];
    assign bus.jtarget_o     = fld_src[25:0];
    assign bus.lu_stall_o    = lu_stall;
    assign bus.bubble_o      = lu_stall;
    assign bus.stall_cnt_o   = stall_cnt_q;
endmodule

// File: tb/tb_if_id_stage.sv
// Directed-vector bench for if_id_stage: the driver queues expected outputs
// per cycle, a negedge monitor pops and compares them.
module tb_if_id_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    if_id_stage_if bus ();

    if_id_stage #(.NOP_INSTR(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        lu;
        logic [15:0] cnt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                         input logic v, input logic fl, input logic st,
                         input logic mr, input logic [4:0] ert);
        @(posedge clk);
        #1;
        rst_n             = r;
        bus.instr_i       = ins;
        bus.pc_plus4_i    = pc;
        bus.if_valid_i    = v;
        bus.flush_i       = fl;
        bus.stall_i       = st;
        bus.ex_mem_read_i = mr;
        bus.ex_rt_i       = ert;
    endtask

    task automatic exp_push(input string name, input logic [31:0] ins, input logic [31:0] pc,
                            input logic v, input logic lu, input logic [15:0] cnt,
                            input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [15:0] imm);
        exp_t e;
        e.at = cyc; e.name = name; e.instr = ins; e.pc = pc; e.valid = v; e.lu = lu;
        e.cnt = cnt; e.op = op; e.rs = rs; e.rt = rt; e.imm = imm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.at != cyc) chk({e.name, "_missed"}, 32'(cyc), 32'(e.at));
            chk({e.name, "_instr"},  bus.id_instr_o,          e.instr);
            chk({e.name, "_pc4"},    bus.id_pc_plus4_o,       e.pc);
            chk({e.name, "_valid"},  32'(bus.id_valid_o),     32'(e.valid));
            chk({e.name, "_lu"},     32'(bus.lu_stall_o),     32'(e.lu));
            chk({e.name, "_bubble"}, 32'(bus.bubble_o),       32'(e.lu));
            chk({e.name, "_cnt"},    32'(bus.stall_cnt_o),    32'(e.cnt));
            chk({e.name, "_op"},     32'(bus.opcode_o),       32'(e.op));
            chk({e.name, "_rs"},     32'(bus.rs_o),           32'(e.rs));
            chk({e.name, "_rt"},     32'(bus.rt_o),           32'(e.rt));
            chk({e.name, "_imm"},    32'(bus.imm16_o),        32'(e.imm));
            $display("cyc %0d %s instr=%h pc4=%h v=%b lu=%b cnt=%h", cyc, e.name,
                     bus.id_instr_o, bus.id_pc_plus4_o, bus.id_valid_o,
                     bus.lu_stall_o, bus.stall_cnt_o);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] ADDI = 32'h2128_0004;
    localparam logic [31:0] ADD  = 32'h0109_5020;
    localparam logic [31:0] LW   = 32'h8D2A_0000;

    initial begin
        bus.instr_i = 32'hFFFF_FFFF; bus.pc_plus4_i = 32'h0; bus.if_valid_i = 1'b1;
        bus.flush_i = 1'b0; bus.stall_i = 1'b0; bus.ex_mem_read_i = 1'b0; bus.ex_rt_i = 5'd0;

        drive(0, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, 0, 0);
        exp_push("rst1", 32'h0, 32'h0, 0, 0, 16'h0, 6'h00, 5'd0, 5'd0, 16'h0);
        drive(0, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, 0, 0);
        exp_push("rst2", 32'h0, 32'h0, 0, 0, 16'h0, 6'h00, 5'd0, 5'd0, 16'h0);
        drive(1, ADDI, 32'h10, 1, 0, 0, 0, 0);
        exp_push("rst3", 32'h0, 32'h0, 0, 0, 16'h0, 6'h00, 5'd0, 5'd0, 16'h0);
        drive(1, ADD, 32'h14, 1, 0, 0, 0, 0);
        exp_push("pass_addi", ADDI, 32'h10, 1, 0, 16'h0, 6'h08, 5'd9, 5'd8, 16'h0004);
        // load writes $8, consumer add reads $8 as rs
        drive(1, 32'h2128_0008, 32'h18, 1, 0, 0, 1, 5'd8);
        exp_push("hazard_rs", ADD, 32'h14, 1, 1, 16'h0, 6'h00, 5'd8, 5'd9, 16'h5020);
        drive(1, LW, 32'h18, 1, 0, 0, 1, 5'd0);
        exp_push("held_rt0", ADD, 32'h14, 1, 0, 16'h1, 6'h00, 5'd8, 5'd9, 16'h5020);
        // lw does not read rt, so a match on rt must not stall
        drive(1, ADD, 32'h1C, 1, 0, 0, 1, 5'd10);
        exp_push("lw_rt_unused", LW, 32'h18, 1, 0, 16'h1, 6'h23, 5'd9, 5'd10, 16'h0000);
        drive(1, ADDI, 32'h20, 1, 0, 0, 1, 5'd9);
        exp_push("hazard_rt", ADD, 32'h1C, 1, 1, 16'h1, 6'h00, 5'd8, 5'd9, 16'h5020);
        drive(1, ADDI, 32'h20, 1, 1, 1, 1, 5'd8);
        exp_push("flush_cyc", ADD, 32'h1C, 1, 1, 16'h2, 6'h00, 5'd8, 5'd9, 16'h5020);
        drive(1, ADDI, 32'h20, 1, 0, 1, 1, 5'd8);
        exp_push("flushed", 32'h0, 32'h0, 0, 0, 16'h3, 6'h00, 5'd0, 5'd0, 16'h0);
        drive(1, ADDI, 32'h20, 1, 0, 0, 0, 5'd0);
        exp_push("ext_stall", 32'h0, 32'h0, 0, 0, 16'h3, 6'h00, 5'd0, 5'd0, 16'h0);
        drive(1, 32'hFFFF_FFFF, 32'h24, 0, 0, 0, 0, 5'd0);
        exp_push("after_stall", ADDI, 32'h20, 1, 0, 16'h3, 6'h08, 5'd9, 5'd8, 16'h0004);
        drive(1, ADD, 32'h28, 1, 0, 0, 0, 5'd0);
        exp_push("invalid_fetch", 32'h0, 32'h24, 0, 0, 16'h3, 6'h00, 5'd0, 5'd0, 16'h0);
        drive(0, ADD, 32'h2C, 1, 0, 0, 1, 5'd8);
        exp_push("rst_midstall", ADD, 32'h28, 1, 0, 16'h3, 6'h00, 5'd8, 5'd9, 16'h5020);
        drive(1, ADD, 32'h2C, 1, 0, 0, 0, 5'd0);
        exp_push("post_rst", 32'h0, 32'h0, 0, 0, 16'h0, 6'h00, 5'd0, 5'd0, 16'h0);
        drive(1, ADD, 32'h30, 1, 0, 0, 1, 5'd8);
        exp_push("sat_start", ADD, 32'h2C, 1, 1, 16'h0, 6'h00, 5'd8, 5'd9, 16'h5020);
        for (int j = 1; j <= 70000; j++) begin
            drive(1, ADD, 32'h30, 1, 0, 0, 1, 5'd8);
            if (j == 65534 || j == 65535 || j == 65536 || j == 70000)
                exp_push($sformatf("sat_%0d", j), ADD, 32'h2C, 1, 1,
                         (j >= 65535) ? 16'hFFFF : 16'(j),
                         6'h00, 5'd8, 5'd9, 16'h5020);
        end
        drive(1, 32'h0, 32'h0, 0, 0, 0, 0, 5'd0);
        drive(1, 32'h0, 32'h0, 0, 0, 0, 0, 5'd0);
        @(posedge clk);
        #1;
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
